// File: rtl/fp_add_pipe.sv
// Three-stage pipelined floating-point adder/subtractor (swap/align, add/LZC, normalise/round/pack).
// Global-stall handshake: every stage advances together whenever the output slot is free or being taken.
module fp_add_pipe #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   op_sub,
    input  logic [EXP_W+MAN_W:0]   a,
    input  logic [EXP_W+MAN_W:0]   b,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [EXP_W+MAN_W:0]   s,
    output logic                   ovf
);

    localparam int W  = 1 + EXP_W + MAN_W;
    localparam int SW = MAN_W + 4;     // hidden + fraction + guard/round/sticky
    localparam int XW = EXP_W + 2;     // headroom for carry and rounding increments

    logic              advance_s;
    logic              v1_r, v2_r, v3_r;

    logic              a_ge_s, sb_s, sign_big_s, sign_small_s;
    logic [W-2:0]      big_s, small_s;
    logic [EXP_W-1:0]  eb_s, es_s, diff_s;
    logic [SW-1:0]     sig_big_s, ext_small_s, shifted_s, align_s;
    logic              lost_s;

    logic              sign1_r, sub1_r;
    logic [EXP_W-1:0]  exp1_r;
    logic [SW-1:0]     sig_a1_r, sig_b1_r;

    logic [SW:0]       sum_s;
    logic [XW-1:0]     lzc_s, limit_s, shift_s;
    logic              zero_s;

    logic              sign2_r;
    logic [EXP_W-1:0]  exp2_r;
    logic [SW:0]       sum2_r;
    logic [XW-1:0]     shift2_r;

    logic [SW-1:0]     norm_s;
    logic [XW-1:0]     exp_n_s, exp_z_s, exp_f_s;
    logic              round_s, ovf_s;
    logic [MAN_W+1:0]  mant_s;
    logic [MAN_W-1:0]  frac_s;
    logic [W-1:0]      res_s;

    assign in_ready  = !v3_r || out_ready;
    assign out_valid = v3_r;
    assign advance_s = in_ready;

    // Stage 1 combinational: order by magnitude, build significands, align the smaller one
    always_comb begin
        a_ge_s = (a[W-2:0] >= b[W-2:0]);
        sb_s   = b[W-1] ^ op_sub;
        if (a_ge_s) begin
            big_s        = a[W-2:0];
            small_s      = b[W-2:0];
            sign_big_s   = a[W-1];
            sign_small_s = sb_s;
        end else begin
            big_s        = b[W-2:0];
            small_s      = a[W-2:0];
            sign_big_s   = sb_s;
            sign_small_s = a[W-1];
        end
        // Denormals behave as exponent 1 with a zero hidden bit
        eb_s        = (big_s[W-2:MAN_W] == {EXP_W{1'b0}}) ? EXP_W'(1) : big_s[W-2:MAN_W];
        es_s        = (small_s[W-2:MAN_W] == {EXP_W{1'b0}}) ? EXP_W'(1) : small_s[W-2:MAN_W];
        sig_big_s   = {|big_s[W-2:MAN_W], big_s[MAN_W-1:0], 3'b000};
        ext_small_s = {|small_s[W-2:MAN_W], small_s[MAN_W-1:0], 3'b000};
        diff_s      = eb_s - es_s;
        shifted_s   = ext_small_s >> diff_s;
        lost_s      = |(ext_small_s & ~({SW{1'b1}} << diff_s));
        if (int'(diff_s) >= MAN_W + 3) begin
            align_s = {{(SW-1){1'b0}}, |ext_small_s};
        end else begin
            align_s = {shifted_s[SW-1:1], shifted_s[0] | lost_s};
        end
    end

    // Stage 1 register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1_r     <= 1'b0;
            sign1_r  <= 1'b0;
            sub1_r   <= 1'b0;
            exp1_r   <= {EXP_W{1'b0}};
            sig_a1_r <= {SW{1'b0}};
            sig_b1_r <= {SW{1'b0}};
        end else if (advance_s) begin
            v1_r     <= in_valid;
            sign1_r  <= sign_big_s;
            sub1_r   <= sign_big_s ^ sign_small_s;
            exp1_r   <= eb_s;
            sig_a1_r <= sig_big_s;
            sig_b1_r <= align_s;
        end
    end

    // Stage 2 combinational: add/subtract and leading-zero count limited by exponent headroom
    always_comb begin
        if (sub1_r) begin
            sum_s = {1'b0, sig_a1_r} - {1'b0, sig_b1_r};
        end else begin
            sum_s = {1'b0, sig_a1_r} + {1'b0, sig_b1_r};
        end
        lzc_s = XW'(SW);
        for (int i = 0; i < SW; i++) begin
            lzc_s = sum_s[i] ? XW'(SW - 1 - i) : lzc_s;
        end
        limit_s = {2'b00, exp1_r - EXP_W'(1)};
        shift_s = (lzc_s > limit_s) ? limit_s : lzc_s;
        zero_s  = (sum_s == {(SW+1){1'b0}});
    end

    // Stage 2 register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v2_r     <= 1'b0;
            sign2_r  <= 1'b0;
            exp2_r   <= {EXP_W{1'b0}};
            sum2_r   <= {(SW+1){1'b0}};
            shift2_r <= {XW{1'b0}};
        end else if (advance_s) begin
            v2_r     <= v1_r;
            sign2_r  <= (sub1_r && zero_s) ? 1'b0 : sign1_r;
            exp2_r   <= exp1_r;
            sum2_r   <= sum_s;
            shift2_r <= shift_s;
        end
    end

    // Stage 3 combinational: normalise, round to nearest even, pack with overflow saturation
    always_comb begin
        if (sum2_r[SW]) begin
            norm_s  = {sum2_r[SW:2], sum2_r[1] | sum2_r[0]};
            exp_n_s = {2'b00, exp2_r} + XW'(1);
        end else begin
            norm_s  = sum2_r[SW-1:0] << shift2_r;
            exp_n_s = {2'b00, exp2_r} - shift2_r;
        end
        exp_z_s = norm_s[SW-1] ? exp_n_s : {XW{1'b0}};
        round_s = norm_s[2] & (norm_s[1] | norm_s[0] | norm_s[3]);
        mant_s  = {1'b0, norm_s[SW-1:3]} + {{(MAN_W+1){1'b0}}, round_s};
        if (mant_s[MAN_W+1]) begin
            frac_s  = {MAN_W{1'b0}};
            exp_f_s = exp_z_s + XW'(1);
        end else begin
            frac_s  = mant_s[MAN_W-1:0];
            exp_f_s = ((exp_z_s == {XW{1'b0}}) && mant_s[MAN_W]) ? XW'(1) : exp_z_s;
        end
        ovf_s = (exp_f_s >= {2'b00, {EXP_W{1'b1}}});
        if (ovf_s) begin
            res_s = {sign2_r, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else begin
            res_s = {sign2_r, exp_f_s[EXP_W-1:0], frac_s};
        end
    end

    // Stage 3 register drives the outputs directly
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v3_r <= 1'b0;
            s    <= {W{1'b0}};
            ovf  <= 1'b0;
        end else if (advance_s) begin
            v3_r <= v2_r;
            s    <= res_s;
            ovf  <= ovf_s;
        end
    end

endmodule

// File: tb/tb_fp_add_pipe.sv
// Scoreboard bench for fp_add_pipe: directed single-precision vectors, backpressure and mid-flight reset.
module tb_fp_add_pipe;

    logic        clk = 1'b0;
    logic        rst, in_valid, in_ready, op_sub, out_valid, out_ready, ovf;
    logic [31:0] a, b, s;

    always #5 clk = ~clk;

    fp_add_pipe #(.EXP_W(8), .MAN_W(23)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op_sub(op_sub),
        .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .s(s), .ovf(ovf)
    );

    typedef struct {
        logic [31:0] s;
        logic        ovf;
        int          acc;
        bit          lat;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;
    int   cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // Monitor: compare presented result with the oldest expectation, pop on transfer
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            chk("in_ready", {31'b0, in_ready}, {31'b0, (!out_valid || out_ready)});
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL spurious_out: got s=%h with no result outstanding", s);
                end else begin
                    e = exp_q[0];
                    chk("s", s, e.s);
                    chk("ovf", {31'b0, ovf}, {31'b0, e.ovf});
                    if (out_ready) begin
                        if (e.lat) chk("latency", 32'(cyc - e.acc), 32'd3);
                        void'(exp_q.pop_front());
                    end
                end
            end
        end
    end

    task automatic issue(input logic [31:0] ia, input logic [31:0] ib, input logic iop,
                         input logic [31:0] es, input logic eo, input bit lat);
        bit   got;
        exp_t e;
        got      = 1'b0;
        a        = ia;
        b        = ib;
        op_sub   = iop;
        in_valid = 1'b1;
        for (int k = 0; k < 50 && !got; k++) begin
            @(negedge clk);
            if (in_ready) begin
                got   = 1'b1;
                e.s   = es;
                e.ovf = eo;
                e.acc = cyc;
                e.lat = lat;
                exp_q.push_back(e);
            end
            @(posedge clk);
            #1;
        end
        if (!got) begin
            n_cmp++;
            n_fail++;
            $display("FAIL accept_timeout: in_ready stayed 0, expected 1");
        end
    endtask

    task automatic drain();
        for (int k = 0; k < 40 && exp_q.size() != 0; k++) @(negedge clk);
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL drain_timeout: %0d results outstanding, expected 0", exp_q.size());
        end
        repeat (4) @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; op_sub = 1'b0; a = 32'h0; b = 32'h0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
        chk("rst_s", s, 32'h0);
        chk("rst_ovf", {31'b0, ovf}, 32'd0);
        #1 rst = 1'b0;

        // Directed vectors, streamed back to back
        issue(32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 1'b0, 1'b1); // 1+2
        issue(32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 1'b0, 1'b1); // 1-1 -> +0
        issue(32'h00000001, 32'h00000001, 1'b0, 32'h00000002, 1'b0, 1'b1); // denormals
        issue(32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 1'b0, 1'b1); // tie, even
        issue(32'h3F800000, 32'h33800001, 1'b0, 32'h3F800001, 1'b0, 1'b1); // above tie
        issue(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 1'b1, 1'b1); // overflow
        issue(32'h3F800000, 32'h40000000, 1'b1, 32'hBF800000, 1'b0, 1'b1); // 1-2
        issue(32'h3FC00000, 32'h3F800000, 1'b1, 32'h3F000000, 1'b0, 1'b1); // 1.5-1
        issue(32'h3F800001, 32'h33800000, 1'b0, 32'h3F800002, 1'b0, 1'b1); // tie, odd
        issue(32'h00400000, 32'h00400000, 1'b0, 32'h00800000, 1'b0, 1'b1); // denorm->normal
        issue(32'h00800001, 32'h00800000, 1'b1, 32'h00000001, 1'b0, 1'b1); // normal->denorm
        issue(32'hC0400000, 32'h3F800000, 1'b0, 32'hC0000000, 1'b0, 1'b1); // -3+1
        issue(32'h3FFFFFFF, 32'h33800000, 1'b0, 32'h40000000, 1'b0, 1'b1); // round carry-out
        in_valid = 1'b0;
        drain();

        // Backpressure window on the output
        fork
            begin
                issue(32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 1'b0, 1'b0);
                issue(32'h40000000, 32'h40000000, 1'b0, 32'h40800000, 1'b0, 1'b0);
                issue(32'h40800000, 32'h40800000, 1'b0, 32'h41000000, 1'b0, 1'b0);
                issue(32'h41000000, 32'h41000000, 1'b0, 32'h41800000, 1'b0, 1'b0);
                issue(32'h3F800000, 32'h3F000000, 1'b0, 32'h3FC00000, 1'b0, 1'b0);
                in_valid = 1'b0;
            end
            begin
                repeat (3) @(posedge clk);
                #1 out_ready = 1'b0;
                repeat (2) @(negedge clk);
                chk("stall_out_valid", {31'b0, out_valid}, 32'd1);
                chk("stall_in_ready", {31'b0, in_ready}, 32'd0);
                repeat (3) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        drain();

        // Reset with two operations in flight
        out_ready = 1'b0;
        issue(32'h41200000, 32'h41200000, 1'b0, 32'h41A00000, 1'b0, 1'b0);
        issue(32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 1'b0, 1'b0);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        chk("pre_rst_valid", {31'b0, out_valid}, 32'd1);
        #1 rst = 1'b1;
        #1;
        chk("mid_rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("mid_rst_in_ready", {31'b0, in_ready}, 32'd1);
        chk("mid_rst_s", s, 32'h0);
        chk("mid_rst_ovf", {31'b0, ovf}, 32'd0);
        exp_q.delete();
        @(posedge clk);
        #2 rst = 1'b0;
        out_ready = 1'b1;
        issue(32'h40400000, 32'h40400000, 1'b0, 32'h40C00000, 1'b0, 1'b1); // 3+3
        in_valid = 1'b0;
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/fp_add_pipe.md
FP_ADD_PIPE -- requirements
Module: fp_add_pipe

Interface
REQ-001 SHALL have parameter EXP_W, default 8, meaning exponent field width in bits.
REQ-002 SHALL have parameter MAN_W, default 23, meaning stored mantissa (fraction) width in bits; operand width W = 1+EXP_W+MAN_W.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on rising edge.
REQ-004 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port in_valid, input, 1, meaning operands are presented this cycle.
REQ-006 SHALL have port in_ready, output, 1, meaning the block accepts operands this cycle.
REQ-007 SHALL have port op_sub, input, 1, where 0 computes a+b and 1 computes a-b (sign of b inverted before alignment).
REQ-008 SHALL have port a, input, W, the first IEEE-style operand {sign, exp, frac}.
REQ-009 SHALL have port b, input, W, the second operand in the same format.
REQ-010 SHALL have port out_valid, output, 1, meaning s/ovf hold a result.
REQ-011 SHALL have port out_ready, input, 1, meaning the consumer takes the result this cycle.
REQ-012 SHALL have port s, output, W, the rounded sum.
REQ-013 SHALL have port ovf, output, 1, meaning the result overflowed to infinity.

Function
REQ-014 SHALL be a 3-stage pipeline: S1 swap/align, S2 add/subtract plus leading-zero count, S3 normalise/round/pack; latency 3 cycles from accepted input to out_valid with no backpressure.
REQ-015 SHALL transfer an input when in_valid && in_ready, and an output when out_valid && out_ready.
REQ-016 SHALL drive in_ready = !out_valid || out_ready (global stall); while stalled every stage holds its contents unchanged and no bubble is inserted or lost.
REQ-017 SHALL sustain one result per cycle when out_ready is held high.
REQ-018 S1 SHALL order operands by magnitude (exponent, then fraction) so the larger is A; hidden bit = 1 unless exp == 0; a denormal is treated as exponent 1.
REQ-019 S1 SHALL right-shift the smaller significand by the exponent difference, keeping guard, round and a sticky bit (OR of all shifted-out bits); a difference >= MAN_W+3 yields zero significand with sticky = (B nonzero).
REQ-020 S2 SHALL add significands when effective signs match, else subtract smaller from larger; result sign = sign of A.
REQ-021 S2 SHALL compute the leading-zero count of the difference, with the left shift limited to exp_A-1 so the result becomes denormal rather than going below exponent 1.
REQ-022 S3 SHALL normalise: on carry-out shift right 1 and increment exponent; otherwise shift left by the limited count and decrement exponent accordingly; exponent 0 if the hidden bit remains 0.
REQ-023 S3 SHALL round to nearest, ties to even, using guard/round/sticky, and renormalise if rounding carries out.
REQ-024 SHALL, if the final exponent >= 2^EXP_W-1, output {sign, all-ones exp, zero frac} with ovf = 1; otherwise ovf = 0.
REQ-025 SHALL output +0 when an effective subtraction yields an exact zero.
REQ-026 SHALL not decode NaN/infinity inputs specially; all-ones exponents are processed as ordinary numbers (documented limitation).

Reset
REQ-027 SHALL, on rst high, asynchronously clear all stage-valid flags, so out_valid = 0 and in_ready = 1; s = 0 and ovf = 0.
REQ-028 SHALL discard in-flight operations on reset mid-operation; no result is emitted from pre-reset inputs after rst falls.
REQ-029 SHALL accept inputs on the first rising edge after rst deasserts.

Verification
REQ-030 a=0x3F800000, b=0x40000000, op_sub=0, out_ready=1 -> after 3 cycles s=0x40400000, ovf=0.
REQ-031 a=0x3F800000, b=0x3F800000, op_sub=1 -> s=0x00000000; a=0x00000001, b=0x00000001, op_sub=0 -> s=0x00000002.
REQ-032 a=0x3F800000, b=0x33800000 (exact tie) -> s=0x3F800000; b=0x33800001 -> s=0x3F800001.
REQ-033 a=b=0x7F7FFFFF, op_sub=0 -> s=0x7F800000, ovf=1.
REQ-034 5 back-to-back inputs, out_ready low for cycles 4-7 -> in_ready low while out_valid && !out_ready, all 5 results delivered in order, none duplicated.
REQ-035 rst pulsed with 2 ops in flight -> out_valid=0 immediately, no stale result after release, next input's result appears 3 cycles after acceptance.
